// File: rtl/chan_sel_pkg.sv
// Shared types and constants for the channel-select / UART TX feeder.
package chan_sel_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } tx_state_t;

  localparam int DEB_CYC_DEF  = 16;
  localparam int SCAN_PER_DEF = 1000000;

  // Index width that stays at least one bit even for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_sel_tx_if.sv
// Valid/ready word link from the channel selector to the UART transmitter.
interface chan_sel_tx_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/chan_sel_tx_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge press pulse.
module btn_debounce
  import chan_sel_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = clog2_min1(DEB_CYC);

  logic          s1, s2, lvl, lvl_q;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a level only after DEB_CYC consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_q <= lvl;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = lvl & ~lvl_q;

endmodule

// File: rtl/chan_sel_tx.sv
// Channel selector feeding the UART TX block.
// Optional auto-scan stepping is compiled in with CHAN_SEL_AUTO_SCAN_EN.
module chan_sel_tx
  import chan_sel_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DW       = 8,
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int SCAN_PER = SCAN_PER_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NCH*DW-1:0]           ch_data,
  input  logic                        btn_up,
  input  logic                        btn_dn,
  input  logic                        send_req,
  input  logic                        auto_mode,
  output logic [clog2_min1(NCH)-1:0]  sel,
  output logic [DW-1:0]               sel_data,
  output logic                        sel_chg,
  chan_sel_tx_if.master               tx
);

  localparam int SW = clog2_min1(NCH);

  logic          up_p, dn_p, auto_step;
  logic          inc, dec, req;
  logic [SW-1:0] sel_nxt;
  logic [DW-1:0] cap;

  tx_state_t     state_q, state_n;
  logic          pending_q, pending_n;
  logic          valid_q, valid_n;
  logic [DW-1:0] data_q, data_n;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (.clk(clk), .rst(rst), .btn(btn_up), .press(up_p));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dn (.clk(clk), .rst(rst), .btn(btn_dn), .press(dn_p));

`ifdef CHAN_SEL_AUTO_SCAN_EN
  localparam int SCW = clog2_min1(SCAN_PER);
  logic [SCW-1:0] scan_cnt;
  logic           scan_tc;

  assign scan_tc   = auto_mode && (scan_cnt == SCW'(SCAN_PER - 1));
  // A button pulse in the terminal cycle wins; the tick is simply lost.
  assign auto_step = scan_tc & ~up_p & ~dn_p;

  // Free-running scan interval counter, held at zero while auto mode is off.
  always_ff @(posedge clk) begin
    if (rst || !auto_mode || scan_tc) scan_cnt <= '0;
    else                              scan_cnt <= scan_cnt + 1'b1;
  end
`else
  logic unused_auto;
  assign unused_auto = auto_mode | (SCAN_PER == 0);
  assign auto_step   = 1'b0;
`endif

  assign inc = (up_p & ~dn_p) | auto_step;
  assign dec = dn_p & ~up_p;
  // The step itself is the request, so the capture sees the post-step index.
  assign req = inc | dec | send_req;

  // Wrapping next-index computation.
  always_comb begin
    sel_nxt = sel;
    if (inc)      sel_nxt = (sel == SW'(NCH - 1)) ? '0 : sel + 1'b1;
    else if (dec) sel_nxt = (sel == '0) ? SW'(NCH - 1) : sel - 1'b1;
  end

  assign cap      = ch_data[sel_nxt*DW +: DW];
  assign sel_data = ch_data[sel*DW +: DW];

  // Selection index register and change pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= '0;
      sel_chg <= 1'b0;
    end else begin
      sel     <= sel_nxt;
      sel_chg <= inc | dec;
    end
  end

  // TX state, pending flag and held data word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_n;
      pending_q <= pending_n;
      valid_q   <= valid_n;
      data_q    <= data_n;
    end
  end

  // TX next state: capture on request, hold while busy, chain a pending send back-to-back.
  always_comb begin
    state_n   = state_q;
    pending_n = pending_q;
    valid_n   = valid_q;
    data_n    = data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          data_n  = cap;
          valid_n = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (valid_q && tx.tx_ready) begin
          // A request landing in the handshake cycle folds into the pending send.
          if (pending_q || req) begin
            data_n    = cap;
            valid_n   = 1'b1;
            pending_n = 1'b0;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end else if (req) begin
          pending_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;

endmodule
